instruction_fetch_unit: RTL and testbench

Upstream stage of the immediate generator and decoder: owns the program counter and fetches 32-bit instructions over a ready/valid memory interface. Presents each fetched instruction and its PC to the decode/immediate stage with a valid/ready handshake. Computes the next PC from the resolved branch decision and the sign-extended immediate returned by the immediate generator.

---
 rtl/fetch_pkg.sv | 6 +
 rtl/pc_next_logic.sv | 16 +
 rtl/instruction_fetch_unit.sv | 88 ++++++++
 tb/tb_instruction_fetch_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction fetch unit.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;
    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/pc_next_logic.sv
// pc_next_logic: next-PC adder/mux (sequential or branch target) with misalignment flag.
module pc_next_logic
    import fetch_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] pc,
    input  logic            taken,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);
    // Addition wraps modulo 2^XLEN by width truncation.
    assign next_pc    = pc + (taken ? imm : XLEN'(PC_STEP));
    assign misaligned = |next_pc[1:0];
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches words over ready/valid memory and
// hands them to decode; a misaligned next-PC halts fetching until reset.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_imm,
    output logic            fetch_fault
);
    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    pc_next_logic #(.XLEN(XLEN)) u_pc_next (
        .pc        (instr_pc),
        .taken     (branch_taken),
        .imm       (branch_imm),
        .next_pc   (next_pc),
        .misaligned(misaligned)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= NOP_INSTR;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_req && imem_ready) begin
                        imem_req <= 1'b0;
                        state    <= WAIT;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        if (misaligned) begin
                            fetch_fault <= 1'b1;
                            state       <= HALT;
                        end else begin
                            // Raise the request immediately so back-to-back fetches take 3 cycles.
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                HALT: begin
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [63:0] branch_imm;
    logic        fetch_fault;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch_taken(branch_taken),
        .branch_imm  (branch_imm),
        .fetch_fault (fetch_fault)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH with imem_req=1; ends in HOLD with the word latched.
    task automatic fetch_one(input logic [31:0] word);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic consume(input logic taken, input logic [63:0] imm);
        instr_ready  = 1'b1;
        branch_taken = taken;
        branch_imm   = imm;
        tick();
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = '0;
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_imm = '0;
        tick(); tick();
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_instr", instr, 64'h13);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_fault", fetch_fault, 0);

        // Zero-wait fetch with downstream always ready
        imem_ready = 1'b1; instr_ready = 1'b1; imem_rdata = 32'h00500093;
        rst_n = 1'b1;
        tick();
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 0);
        tick();
        check("wait_req", imem_req, 0);
        check("wait_valid", instr_valid, 0);
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        imem_ready  = 1'b0;
        check("hold_valid", instr_valid, 1);
        check("hold_instr", instr, 64'h00500093);
        check("hold_pc", instr_pc, 0);
        tick();
        check("seq_req", imem_req, 1);
        check("seq_addr", imem_addr, 64'h4);
        check("seq_valid", instr_valid, 0);
        check("seq_nop", instr, 64'h13);
        instr_ready = 1'b0;

        // Memory stalls: request and address stay put
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_req", imem_req, 1);
            check("stall_addr", imem_addr, 64'h4);
        end
        imem_ready = 1'b1;
        tick();
        check("stall_accept", imem_req, 0);
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00100113;
        tick();
        imem_rvalid = 1'b0;

        // Downstream back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_instr", instr, 64'h00100113);
            check("bp_pc", instr_pc, 64'h4);
            check("bp_valid", instr_valid, 1);
            check("bp_req", imem_req, 0);
        end
        consume(1'b0, 64'h40);
        check("bp_next_addr", imem_addr, 64'h8);
        check("bp_next_req", imem_req, 1);

        // Branches: forward, negative wrap, forward
        fetch_one(32'h0);
        check("br0_pc", instr_pc, 64'h8);
        consume(1'b1, 64'hF8);
        check("br0_addr", imem_addr, 64'h100);
        fetch_one(32'h0);
        check("br1_pc", instr_pc, 64'h100);
        consume(1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
        check("br_neg_addr", imem_addr, 64'hF0);
        fetch_one(32'h0);
        consume(1'b1, 64'h10);
        check("br2_addr", imem_addr, 64'h100);
        fetch_one(32'h0);
        consume(1'b1, 64'h20);
        check("br_pos_addr", imem_addr, 64'h120);
        fetch_one(32'h0);
        consume(1'b1, 64'hFFFF_FFFF_FFFF_FEE8);
        check("br3_addr", imem_addr, 64'h8);

        // Misaligned target halts fetching
        fetch_one(32'h0);
        check("mis_pc", instr_pc, 64'h8);
        consume(1'b1, 64'h2);
        check("mis_fault", fetch_fault, 1);
        check("mis_req", imem_req, 0);
        check("mis_valid", instr_valid, 0);
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_fault", fetch_fault, 1);
            check("halt_req", imem_req, 0);
        end
        rst_n = 1'b0;
        #1;
        check("halt_rst_fault", fetch_fault, 0);
        check("halt_rst_addr", imem_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, 0);

        // Reset during WAIT, then a stale rvalid after release
        tick();
        check("w_req", imem_req, 0);
        imem_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        imem_rvalid = 1'b0;
        check("late_valid", instr_valid, 0);
        check("late_instr", instr, 64'h13);
        check("late_req", imem_req, 1);
        check("late_addr", imem_addr, 0);
        tick();
        check("late_valid2", instr_valid, 0);
        check("late_req2", imem_req, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
